// File: rtl/weight_load_ctrl_if.sv
// weight_load_ctrl_if
// Upstream weight stream (valid/ready) between the weight fetch engine and
// the weight load controller.
//   weight_in_valid  - upstream word valid
//   weight_in_data   - 16-bit weight word
//   weight_in_ready  - controller accepts the word this cycle
// Modports: master = fetch engine (source), slave = weight_load_ctrl (sink).
interface weight_load_ctrl_if;
    logic        weight_in_valid;
    logic [15:0] weight_in_data;
    logic        weight_in_ready;

    modport master (
        output weight_in_valid,
        output weight_in_data,
        input  weight_in_ready
    );

    modport slave (
        input  weight_in_valid,
        input  weight_in_data,
        output weight_in_ready
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl
// Loads one layer of 16-bit CNN weights from the upstream stream into the
// local weight memory, one layer per load_req.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   load_req, load_layer - one-cycle load request, layer id (1,2,4,5,7)
//   wif (slave)          - upstream valid/ready weight stream
//   write_weight_*       - memory write strobe, data, flat word address
//   weight_fsm_cs        - state code for the memory packing logic
//   weight_store_done    - one-cycle pulse once the layer is fully written
//   weights_ready        - resident layer complete, reads allowed
//   load_busy            - load in progress
//   perf_stall_cnt       - upstream starvation counter
// Optional feature: define WEIGHT_LOAD_PERF_EN to build the stall counter;
// otherwise perf_stall_cnt is tied to zero.
module weight_load_ctrl #(
    parameter int L1_WORDS = 216,
    parameter int L2_WORDS = 576,
    parameter int L4_WORDS = 576,
    parameter int L5_WORDS = 576,
    parameter int L7_WORDS = 400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_req,
    input  logic [2:0]         load_layer,
    weight_load_ctrl_if.slave  wif,
    output logic               write_weight_signal,
    output logic [15:0]        write_weight_data,
    output logic [15:0]        write_weight_addr,
    output logic [3:0]         weight_fsm_cs,
    output logic               weight_store_done,
    output logic               weights_ready,
    output logic               load_busy,
    output logic [15:0]        perf_stall_cnt
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0000,
        ST_L1     = 4'b0001,
        ST_L2     = 4'b0010,
        ST_L4     = 4'b0011,
        ST_L5     = 4'b0100,
        ST_L7     = 4'b0101,
        ST_FINISH = 4'b1111
    } state_t;

    state_t      state;
    logic [15:0] n_words;
    logic [15:0] acc_cnt;
    logic [15:0] wr_cnt;

    logic        req_ok;
    state_t      req_state;
    logic [15:0] req_words;
    logic        in_lx;
    logic        accept;
    logic        can_start;
    logic        last_write;

    // Layer id decode; unsupported ids leave req_ok low so the request is dropped.
    always_comb begin
        req_ok    = 1'b1;
        req_state = ST_IDLE;
        req_words = 16'd0;
        case (load_layer)
            3'd1: begin req_state = ST_L1; req_words = 16'(L1_WORDS); end
            3'd2: begin req_state = ST_L2; req_words = 16'(L2_WORDS); end
            3'd4: begin req_state = ST_L4; req_words = 16'(L4_WORDS); end
            3'd5: begin req_state = ST_L5; req_words = 16'(L5_WORDS); end
            3'd7: begin req_state = ST_L7; req_words = 16'(L7_WORDS); end
            default: req_ok = 1'b0;
        endcase
    end

    assign in_lx               = (state != ST_IDLE) && (state != ST_FINISH);
    assign wif.weight_in_ready = in_lx && (acc_cnt < n_words);
    assign accept              = wif.weight_in_valid && wif.weight_in_ready;
    assign can_start           = load_req && req_ok &&
                                 ((state == ST_IDLE) || (state == ST_FINISH));
    // The last word is on the memory port this cycle; leave for FINISH at the edge.
    assign last_write          = write_weight_signal &&
                                 (write_weight_addr == (n_words - 16'd1));

    assign weight_fsm_cs = state;
    assign load_busy     = in_lx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            n_words             <= 16'd0;
            acc_cnt             <= 16'd0;
            wr_cnt              <= 16'd0;
            write_weight_signal <= 1'b0;
            write_weight_data   <= 16'd0;
            write_weight_addr   <= 16'd0;
            weight_store_done   <= 1'b0;
            weights_ready       <= 1'b0;
        end else begin
            write_weight_signal <= 1'b0;
            weight_store_done   <= 1'b0;
            if (can_start) begin
                state         <= req_state;
                n_words       <= req_words;
                acc_cnt       <= 16'd0;
                wr_cnt        <= 16'd0;
                weights_ready <= 1'b0;
            end else if (in_lx) begin
                // Accepted word appears on the memory port one cycle later.
                if (accept) begin
                    acc_cnt             <= acc_cnt + 16'd1;
                    wr_cnt              <= wr_cnt + 16'd1;
                    write_weight_signal <= 1'b1;
                    write_weight_data   <= wif.weight_in_data;
                    write_weight_addr   <= wr_cnt;
                end
                if (last_write) begin
                    state             <= ST_FINISH;
                    weight_store_done <= 1'b1;
                    weights_ready     <= 1'b1;
                end
            end
        end
    end

`ifdef WEIGHT_LOAD_PERF_EN
    logic [15:0] stall_cnt;

    // Counts cycles the controller could take a word but upstream had none.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (can_start) begin
            stall_cnt <= 16'd0;
        end else if (in_lx && wif.weight_in_ready && !wif.weight_in_valid &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl
// Self-checking bench for weight_load_ctrl: a directed vector table, then
// whole-layer loads checked cycle by cycle against a transaction-level model.
module tb_weight_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [2:0]  load_layer;
    logic        write_weight_signal;
    logic [15:0] write_weight_data;
    logic [15:0] write_weight_addr;
    logic [3:0]  weight_fsm_cs;
    logic        weight_store_done;
    logic        weights_ready;
    logic        load_busy;
    logic [15:0] perf_stall_cnt;

    weight_load_ctrl_if wif();

    weight_load_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_req            (load_req),
        .load_layer          (load_layer),
        .wif                 (wif),
        .write_weight_signal (write_weight_signal),
        .write_weight_data   (write_weight_data),
        .write_weight_addr   (write_weight_addr),
        .weight_fsm_cs       (weight_fsm_cs),
        .weight_store_done   (weight_store_done),
        .weights_ready       (weights_ready),
        .load_busy           (load_busy),
        .perf_stall_cnt      (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 idle, 1 loading, 2 finished.
    int          m_phase = 0;
    int          m_layer = 0;
    int          m_n     = 0;
    int          m_acc   = 0;
    int          m_shown = 0;
    int          m_perf  = 0;
    logic        e_wsig  = 1'b0;
    logic [15:0] e_wdata = 16'd0;
    logic [15:0] e_waddr = 16'd0;
    logic        e_done  = 1'b0;
    logic        e_wrdy  = 1'b0;

    int obs_done   = 0;
    int obs_writes = 0;

    typedef struct {
        logic        rst;
        logic        req;
        logic [2:0]  layer;
        logic        valid;
        logic [15:0] data;
        logic [3:0]  cs;
        logic        busy;
        logic        ready;
        logic        wsig;
        logic [15:0] wdata;
        logic [15:0] waddr;
        logic        done;
        logic        wrdy;
    } vec_t;

    vec_t vecs[10];

    function automatic int words_for(input logic [2:0] lay);
        case (lay)
            3'd1: return 216;
            3'd2: return 576;
            3'd4: return 576;
            3'd5: return 576;
            3'd7: return 400;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] code_for(input int lay);
        case (lay)
            1: return 4'b0001;
            2: return 4'b0010;
            4: return 4'b0011;
            5: return 4'b0100;
            7: return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic model_ready();
        return (m_phase == 1) && (m_acc < m_n);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic req, input logic [2:0] lay,
                                  input logic v, input logic [15:0] d);
        rst                 = r;
        load_req            = req;
        load_layer          = lay;
        wif.weight_in_valid = v;
        wif.weight_in_data  = d;
    endtask

    // Reference behaviour for one clock edge, in terms of loads and word counts.
    task automatic model_edge(input logic r, input logic req, input logic [2:0] lay,
                              input logic v, input logic [15:0] d);
        logic rdy;
        rdy = model_ready();
        if (r) begin
            m_phase = 0; m_layer = 0; m_n = 0; m_acc = 0; m_shown = 0; m_perf = 0;
            e_wsig = 1'b0; e_wdata = 16'd0; e_waddr = 16'd0; e_done = 1'b0; e_wrdy = 1'b0;
        end else begin
            e_done = 1'b0;
            e_wsig = 1'b0;
            if (req && words_for(lay) != 0 && m_phase != 1) begin
                m_phase = 1; m_layer = int'(lay); m_n = words_for(lay);
                m_acc = 0; m_shown = 0; m_perf = 0; e_wrdy = 1'b0;
            end else if (m_phase == 1) begin
                if (m_shown == m_n) begin
                    m_phase = 2; e_done = 1'b1; e_wrdy = 1'b1;
                end
                if (rdy && !v && m_perf != 65535) m_perf++;
                if (rdy && v) begin
                    e_wsig  = 1'b1;
                    e_wdata = d;
                    e_waddr = 16'(m_shown);
                    m_shown++;
                    m_acc++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic req, input logic [2:0] lay,
                        input logic v, input logic [15:0] d);
        logic [3:0]  exp_cs;
        logic [15:0] exp_perf;
        @(negedge clk);
        apply_stimulus(r, req, lay, v, d);
        #1;
        check_output("in_ready", 32'(wif.weight_in_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge(r, req, lay, v, d);
        #1;
        exp_cs = (m_phase == 0) ? 4'b0000 : (m_phase == 2) ? 4'b1111 : code_for(m_layer);
`ifdef WEIGHT_LOAD_PERF_EN
        exp_perf = 16'(m_perf);
`else
        exp_perf = 16'd0;
`endif
        check_output("fsm_cs", 32'(weight_fsm_cs), 32'(exp_cs));
        check_output("busy", 32'(load_busy), 32'(m_phase == 1));
        check_output("wsig", 32'(write_weight_signal), 32'(e_wsig));
        check_output("wdata", 32'(write_weight_data), 32'(e_wdata));
        check_output("waddr", 32'(write_weight_addr), 32'(e_waddr));
        check_output("store_done", 32'(weight_store_done), 32'(e_done));
        check_output("weights_ready", 32'(weights_ready), 32'(e_wrdy));
        check_output("perf", 32'(perf_stall_cnt), 32'(exp_perf));
        if (weight_store_done === 1'b1) obs_done++;
        if (write_weight_signal === 1'b1) obs_writes++;
    endtask

    // pattern: 0 valid always with data=index, 1 valid toggling, 2 random valid.
    task automatic run_load(input logic [2:0] lay, input int pattern,
                            input logic [2:0] mid_layer, input int stall_at);
        int   cyc;
        int   stall_n;
        int   n;
        logic v;
        logic req;
        logic [15:0] d;
        n = words_for(lay);
        obs_done = 0;
        obs_writes = 0;
        step(1'b0, 1'b1, lay, 1'b0, 16'd0);
        cyc = 0;
        stall_n = 0;
        while (m_phase == 1 && cyc < 6 * n + 400) begin
            case (pattern)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(3) != 0);
            endcase
            d = (pattern == 0) ? 16'(m_acc) : 16'($urandom);
            if (stall_at >= 0 && m_acc == stall_at && stall_n < 300) begin
                v = 1'b0;
                stall_n++;
            end
            req = (mid_layer != 3'd0) && (cyc == 50);
            step(1'b0, req, req ? mid_layer : lay, v, d);
            cyc++;
        end
        if (m_phase == 1) begin
            errors++;
            $display("[TB] FAIL load_timeout layer %0d: got no finish expected finish", lay);
        end
        step(1'b0, 1'b0, lay, 1'b1, 16'hBEEF);
        step(1'b0, 1'b0, lay, 1'b0, 16'h0);
        check_output("done_pulses", 32'(obs_done), 32'd1);
        check_output("write_count", 32'(obs_writes), 32'(n));
    endtask

    initial begin
        // rst req lay valid data | cs busy ready wsig wdata waddr done wrdy
        vecs[0] = '{1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 3'd3, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 3'd6, 1'b1, 16'h1111, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 3'd1, 1'b0, 16'h0000, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 3'd1, 1'b1, 16'hAAAA, 4'h1, 1'b1, 1'b1, 1'b1, 16'hAAAA, 16'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 3'd1, 1'b0, 16'h5555, 4'h1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 16'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 3'd1, 1'b1, 16'h1234, 4'h1, 1'b1, 1'b1, 1'b1, 16'h1234, 16'd1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 3'd2, 1'b0, 16'h0000, 4'h1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'd1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 3'd0, 1'b1, 16'hFFFF, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0, 1'b0};

        apply_stimulus(1'b1, 1'b0, 3'd0, 1'b0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].rst, vecs[i].req, vecs[i].layer, vecs[i].valid, vecs[i].data);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_cs", i), 32'(weight_fsm_cs), 32'(vecs[i].cs));
            check_output($sformatf("vec%0d_busy", i), 32'(load_busy), 32'(vecs[i].busy));
            check_output($sformatf("vec%0d_ready", i), 32'(wif.weight_in_ready), 32'(vecs[i].ready));
            check_output($sformatf("vec%0d_wsig", i), 32'(write_weight_signal), 32'(vecs[i].wsig));
            check_output($sformatf("vec%0d_wdata", i), 32'(write_weight_data), 32'(vecs[i].wdata));
            check_output($sformatf("vec%0d_waddr", i), 32'(write_weight_addr), 32'(vecs[i].waddr));
            check_output($sformatf("vec%0d_done", i), 32'(weight_store_done), 32'(vecs[i].done));
            check_output($sformatf("vec%0d_wrdy", i), 32'(weights_ready), 32'(vecs[i].wrdy));
        end

        step(1'b1, 1'b0, 3'd0, 1'b0, 16'd0);

        $display("[TB] layer 1, continuous stream");
        run_load(3'd1, 0, 3'd0, -1);

        $display("[TB] layer 7, toggling valid");
        run_load(3'd7, 1, 3'd0, -1);
`ifdef WEIGHT_LOAD_PERF_EN
        check_output("l7_stall_count", 32'(perf_stall_cnt), 32'd399);
`endif

        // Invalid layer while in FINISH is dropped.
        step(1'b0, 1'b1, 3'd3, 1'b0, 16'd0);

        $display("[TB] layer 2 with ignored mid-load request, then layer 4");
        run_load(3'd2, 2, 3'd5, -1);
        run_load(3'd4, 2, 3'd0, -1);

        $display("[TB] layer 5 reset after 100 accepts");
        obs_done = 0;
        step(1'b0, 1'b1, 3'd5, 1'b0, 16'd0);
        for (int i = 0; i < 200 && m_acc < 100; i++)
            step(1'b0, 1'b0, 3'd5, 1'b1, 16'($urandom));
        check_output("accepts_before_reset", 32'(m_acc), 32'd100);
        step(1'b1, 1'b0, 3'd0, 1'b1, 16'h7777);
        step(1'b0, 1'b0, 3'd0, 1'b1, 16'h7777);
        check_output("done_after_reset", 32'(obs_done), 32'd0);
        run_load(3'd5, 2, 3'd0, -1);

        $display("[TB] layer 2 stalled at word 575");
        run_load(3'd2, 0, 3'd0, 575);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
